// File: rtl/spi_packet_rx.sv
// SPI mode-0 slave receiver: oversamples sclk/mosi/cs_n in clk, deserialises
// MSB-first frames of FRAME_BITS bits into {divider, waveform_select}.
//
// Ports:
//   clk, rst_n       : 12 MHz system clock, async active-low reset
//   sclk, mosi, cs_n : raw SPI inputs, asynchronous to clk
//   divider          : last committed divider field (resets to DIV_RESET)
//   waveform_select  : last committed waveform field (resets to 0)
//   frame_valid      : 1-cycle pulse when a good frame is committed
//   frame_error      : 1-cycle pulse when a malformed frame is dropped
//   busy             : high whenever the receiver is not IDLE
//
// Optional build macro SPI_PACKET_RX_TIMEOUT_EN adds an sclk idle timeout
// in RECV that aborts the frame and parks in HOLD until cs_n rises.
module spi_packet_rx #(
    parameter int FRAME_BITS = 18,
    parameter int WAVE_BITS = 2,
    parameter logic [FRAME_BITS-WAVE_BITS-1:0] DIV_RESET = 16'd5,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sclk,
    input  logic                            mosi,
    input  logic                            cs_n,
    output logic [FRAME_BITS-WAVE_BITS-1:0] divider,
    output logic [WAVE_BITS-1:0]            waveform_select,
    output logic                            frame_valid,
    output logic                            frame_error,
    output logic                            busy
);

    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_MAX = 5'd31;

`ifdef SPI_PACKET_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        COMMIT,
        ABORT,
        HOLD
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        RECV,
        COMMIT,
        ABORT
    } state_t;
`endif

    state_t state, state_nxt;

    logic sclk_s1, sclk_s2, sclk_d;
    logic mosi_s1, mosi_s2;
    logic cs_s1, cs_s2, cs_d;

    logic sclk_rise, cs_rise, cs_fall;
    logic hold_cs_hist;

    logic [FRAME_BITS-1:0] shift, shift_nxt;
    logic [4:0] cnt, cnt_nxt;

`ifdef SPI_PACKET_RX_TIMEOUT_EN
    logic [TO_W-1:0] idle_cnt, idle_nxt;
    logic to_flag, to_nxt;
`endif

    // A cs_n fall seen during COMMIT/ABORT stays pending in cs_d so
    // that IDLE still sees the edge on the following cycle.
    assign hold_cs_hist = (state == COMMIT) || (state == ABORT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_d  <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_d    <= 1'b1;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
            cs_s1   <= cs_n;
            cs_s2   <= cs_s1;
            if (!hold_cs_hist) begin
                cs_d <= cs_s2;
            end
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign cs_rise   = cs_s2 & ~cs_d;
    assign cs_fall   = ~cs_s2 & cs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shift <= '0;
            cnt   <= '0;
`ifdef SPI_PACKET_RX_TIMEOUT_EN
            idle_cnt <= '0;
            to_flag  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            shift <= shift_nxt;
            cnt   <= cnt_nxt;
`ifdef SPI_PACKET_RX_TIMEOUT_EN
            idle_cnt <= idle_nxt;
            to_flag  <= to_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift;
        cnt_nxt   = cnt;
`ifdef SPI_PACKET_RX_TIMEOUT_EN
        idle_nxt = idle_cnt;
        to_nxt   = to_flag;
`endif
        unique case (state)
            IDLE: begin
                if (cs_fall) begin
                    shift_nxt = '0;
                    cnt_nxt   = '0;
                    state_nxt = RECV;
`ifdef SPI_PACKET_RX_TIMEOUT_EN
                    idle_nxt = '0;
                    to_nxt   = 1'b0;
`endif
                end
            end
            RECV: begin
                // Shift/count first so a coincident cs_n rise sees the
                // final bit in the frame length check.
                if (sclk_rise) begin
                    shift_nxt = {shift[FRAME_BITS-2:0], mosi_s2};
                    if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + 5'd1;
                    end
                end
                unique case (1'b1)
                    cs_rise && (cnt_nxt == FRAME_CNT): state_nxt = COMMIT;
                    cs_rise && (cnt_nxt != FRAME_CNT): state_nxt = ABORT;
                    default: ;
                endcase
`ifdef SPI_PACKET_RX_TIMEOUT_EN
                if (!cs_rise) begin
                    if (sclk_rise) begin
                        idle_nxt = '0;
                    end else if (idle_cnt == TO_MAX) begin
                        state_nxt = ABORT;
                        to_nxt    = 1'b1;
                    end else begin
                        idle_nxt = idle_cnt + 1'b1;
                    end
                end
`endif
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            ABORT: begin
`ifdef SPI_PACKET_RX_TIMEOUT_EN
                state_nxt = to_flag ? HOLD : IDLE;
                to_nxt    = 1'b0;
`else
                state_nxt = IDLE;
`endif
            end
`ifdef SPI_PACKET_RX_TIMEOUT_EN
            HOLD: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divider         <= DIV_RESET;
            waveform_select <= '0;
            frame_valid     <= 1'b0;
            frame_error     <= 1'b0;
        end else begin
            frame_valid <= (state == COMMIT);
            frame_error <= (state == ABORT);
            if (state == COMMIT) begin
                divider         <= shift[FRAME_BITS-1:WAVE_BITS];
                waveform_select <= shift[WAVE_BITS-1:0];
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
